// File: rtl/dpi_pkt_sequencer_pkg.sv
// dpi_pkt_sequencer_pkg: shared widths and FSM encoding for the DPI packet sequencer
package dpi_pkt_sequencer_pkg;
  localparam int STREAM_ID_W = 6;
  localparam int CHAR_W = 8;
  localparam int PKT_CNT_W = 16;
  localparam int NUM_STREAMS = 1 << STREAM_ID_W;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_STREAM,
    S_DRAIN,
    S_EOP
  } state_t;
endpackage

// File: rtl/dpi_stream_table.sv
// dpi_stream_table: seen-stream bitmap and per-stream enable RAM with registered lookup
module dpi_stream_table
  import dpi_pkt_sequencer_pkg::*;
#(
  parameter int NUM_REGEX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [STREAM_ID_W-1:0] i_waddr,
  input  logic [NUM_REGEX-1:0]   i_wdata,
  input  logic                   i_flush,
  input  logic                   i_set,
  input  logic [STREAM_ID_W-1:0] i_set_id,
  input  logic                   i_rd,
  input  logic [STREAM_ID_W-1:0] i_raddr,
  output logic                   o_new,
  output logic [NUM_REGEX-1:0]   o_enable
);
  logic [NUM_STREAMS-1:0] r_seen;
  logic [NUM_REGEX-1:0]   r_ram [NUM_STREAMS];
  logic                   r_new;
  logic [NUM_REGEX-1:0]   r_en;
  // flush clears first so a coincident set keeps its bit
  always_ff @(posedge clk)
    if (rst) r_seen <= '0;
    else r_seen <= (i_flush ? '0 : r_seen) | (i_set ? (NUM_STREAMS'(1) << i_set_id) : '0);
  always_ff @(posedge clk)
    if (rst) for (int k = 0; k < NUM_STREAMS; k++) r_ram[k] <= '0;
    else if (i_we) r_ram[i_waddr] <= i_wdata;
  always_ff @(posedge clk)
    if (rst) begin
      r_new <= 1'b0;
      r_en  <= '0;
    end else if (i_rd) begin
      r_new <= ~r_seen[i_raddr];
      r_en  <= r_ram[i_raddr];
    end
  assign o_new    = r_new;
  assign o_enable = r_en;
endmodule

// File: rtl/dpi_pkt_sequencer.sv
// dpi_pkt_sequencer: paces packet bytes onto a bank of DPI matchers with restore/eop framing
module dpi_pkt_sequencer
  import dpi_pkt_sequencer_pkg::*;
#(
  parameter int NUM_REGEX = 8,
  parameter int LOAD_GAP  = 2,
  parameter int DRAIN_CYC = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHAR_W-1:0]      in_data,
  input  logic                   in_vld,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [STREAM_ID_W-1:0] in_stream_id,
  output logic                   in_rdy,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_stream_id,
  input  logic [NUM_REGEX-1:0]   cfg_enable,
  input  logic                   cfg_flush,
  output logic [CHAR_W-1:0]      char_in,
  output logic                   char_in_vld,
  output logic                   load_state,
  output logic                   eop,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   new_stream_id,
  output logic [NUM_REGEX-1:0]   enable,
  output logic [PKT_CNT_W-1:0]   pkt_count,
  output logic                   proto_err,
  output logic                   busy
);
  state_t                 r_state, w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CHAR_W-1:0]      r_char;
  logic [STREAM_ID_W-1:0] r_sid;
  logic [PKT_CNT_W-1:0]   r_pkt;
  logic                   r_vld, r_load, r_eop, r_perr, r_busy;
  logic                   w_latch, w_orphan, w_hs, w_load_nxt, w_eop_nxt, w_busy_nxt;
  assign w_latch  = (r_state == S_IDLE) & in_vld & in_sop;
  assign w_orphan = (r_state == S_IDLE) & in_vld & ~in_sop;
  assign w_hs     = (r_state == S_STREAM) & in_vld & ~rst;
  assign in_rdy   = ~rst & ((r_state == S_STREAM) | w_orphan);
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_latch) w_next = S_LOAD;
      S_LOAD:   w_next = (LOAD_GAP > 2) ? S_GAP : S_STREAM;
      S_GAP:    if (r_cnt == '0) w_next = S_STREAM;
      S_STREAM: if (w_hs & in_eop) w_next = S_DRAIN;
      S_DRAIN:  if (r_cnt == '0) w_next = S_EOP;
      S_EOP:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_load_nxt = w_next == S_LOAD;
    w_eop_nxt  = w_next == S_EOP;
    w_busy_nxt = w_next != S_IDLE;
  end
  // shared down-counter: GAP length, then drain length after the last byte
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (w_next == S_GAP && r_state != S_GAP) r_cnt <= CNT_W'(LOAD_GAP - 3);
    else if (w_next == S_DRAIN && r_state != S_DRAIN) r_cnt <= CNT_W'(DRAIN_CYC);
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      r_load <= 1'b0;
      r_eop  <= 1'b0;
      r_busy <= 1'b0;
      r_vld  <= 1'b0;
      r_char <= '0;
      r_perr <= 1'b0;
      r_sid  <= '0;
      r_pkt  <= '0;
    end else begin
      r_load <= w_load_nxt;
      r_eop  <= w_eop_nxt;
      r_busy <= w_busy_nxt;
      r_vld  <= w_hs;
      r_char <= w_hs ? in_data : r_char;
      r_perr <= w_orphan;
      r_sid  <= w_latch ? in_stream_id : r_sid;
      r_pkt  <= r_pkt + PKT_CNT_W'(r_state == S_EOP);
    end
  dpi_stream_table #(.NUM_REGEX(NUM_REGEX)) u_table (
    .clk      (clk),
    .rst      (rst),
    .i_we     (cfg_we),
    .i_waddr  (cfg_stream_id),
    .i_wdata  (cfg_enable),
    .i_flush  (cfg_flush),
    .i_set    (r_state == S_LOAD),
    .i_set_id (r_sid),
    .i_rd     (w_latch),
    .i_raddr  (in_stream_id),
    .o_new    (new_stream_id),
    .o_enable (enable)
  );
  assign char_in     = r_char;
  assign char_in_vld = r_vld;
  assign load_state  = r_load;
  assign eop         = r_eop;
  assign stream_id   = r_sid;
  assign pkt_count   = r_pkt;
  assign proto_err   = r_perr;
  assign busy        = r_busy;
endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// tb_dpi_pkt_sequencer: scoreboard bench for headers, byte timing, drain latency and packet count
module tb_dpi_pkt_sequencer;
  localparam int NR = 8;
  localparam int LG = 2;
  localparam int DC = 3;
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic in_vld = 0, in_sop = 0, in_eop = 0, in_rdy;
  logic [5:0] in_stream_id = 0, cfg_stream_id = 0, stream_id;
  logic cfg_we = 0, cfg_flush = 0;
  logic [NR-1:0] cfg_enable = 0, enable;
  logic [7:0] char_in;
  logic char_in_vld, load_state, eop, new_stream_id, proto_err, busy;
  logic [15:0] pkt_count;
  dpi_pkt_sequencer #(.NUM_REGEX(NR), .LOAD_GAP(LG), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_sop(in_sop),
    .in_eop(in_eop), .in_stream_id(in_stream_id), .in_rdy(in_rdy), .cfg_we(cfg_we),
    .cfg_stream_id(cfg_stream_id), .cfg_enable(cfg_enable), .cfg_flush(cfg_flush),
    .char_in(char_in), .char_in_vld(char_in_vld), .load_state(load_state), .eop(eop),
    .stream_id(stream_id), .new_stream_id(new_stream_id), .enable(enable),
    .pkt_count(pkt_count), .proto_err(proto_err), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0]    sid;
    logic          nw;
    logic [NR-1:0] en;
    logic [15:0]   cnt;
  } hdr_t;
  typedef struct {
    logic [7:0] d;
    int         c;
  } chr_t;
  hdr_t q_hdr[$];
  chr_t q_chr[$];
  hdr_t cur;
  chr_t ce;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_perr = 0;
  int load_cyc = 0, eop_cyc = -1000, last_vld = 0;
  logic in_pkt = 0, first = 0, pend = 0;
  logic [63:0] seen_m = 0;
  logic [NR-1:0] en_m [64];
  logic [15:0] pkt_m = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 0;
      pend = 0;
    end
    if (pend) begin
      chk("pkt_count", pkt_count, cur.cnt);
      pend = 0;
    end
    if (load_state) begin
      if (q_hdr.size() == 0) chk("load_unexpected", 1, 0);
      else begin
        cur = q_hdr.pop_front();
        chk("load_sid", stream_id, cur.sid);
        chk("load_new", new_stream_id, cur.nw);
        chk("load_en", enable, cur.en);
        chk("eop_to_load_ge2", 32'(cyc - eop_cyc >= 2), 1);
        load_cyc = cyc;
        in_pkt = 1;
        first = 1;
      end
    end
    if (busy && in_pkt) begin
      chk("sid_hold", stream_id, cur.sid);
      chk("en_hold", enable, cur.en);
    end
    if (char_in_vld) begin
      if (q_chr.size() == 0) chk("char_unexpected", 1, 0);
      else begin
        ce = q_chr.pop_front();
        chk("char_data", char_in, ce.d);
        chk("char_cycle", cyc, ce.c);
      end
      if (first) chk("first_char_lat", cyc - load_cyc, LG);
      first = 0;
      last_vld = cyc;
    end
    if (eop) begin
      chk("eop_in_pkt", in_pkt, 1);
      chk("eop_lat", cyc - last_vld, DC + 1);
      eop_cyc = cyc;
      pend = 1;
      in_pkt = 0;
    end
    if (proto_err) n_perr++;
  end
  task automatic drive_byte(input logic [7:0] d, input logic [5:0] sid, input logic sop,
                            input logic last, input logic fl, input logic exp_char);
    logic ok = 0;
    in_data = d; in_sop = sop; in_eop = last; in_stream_id = sid; in_vld = 1; cfg_flush = fl;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_rdy;
      if (ok && exp_char) q_chr.push_back('{d, cyc + 1});
      @(posedge clk); #1;
      cfg_flush = 0;
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    in_vld = 0; in_sop = 0; in_eop = 0;
  endtask
  task automatic push_hdr(input logic [5:0] sid);
    hdr_t h;
    pkt_m++;
    h.sid = sid; h.nw = !seen_m[sid]; h.en = en_m[sid]; h.cnt = pkt_m;
    q_hdr.push_back(h);
    seen_m[sid] = 1;
  endtask
  task automatic send(input logic [5:0] sid, input logic [7:0] base, input int n,
                      input logic bubble, input int fl_idx);
    push_hdr(sid);
    for (int i = 0; i < n; i++) begin
      drive_byte(base + 8'(i), sid, i == 0, i == n - 1, i == fl_idx, 1);
      if (i == fl_idx) seen_m = 0;
      if (bubble && i != n - 1) begin @(posedge clk); #1; end
    end
  endtask
  task automatic cfg_write(input logic [5:0] a, input logic [NR-1:0] v);
    cfg_we = 1; cfg_stream_id = a; cfg_enable = v;
    @(posedge clk); #1;
    cfg_we = 0;
    en_m[a] = v;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) chk("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_char"}, char_in, 0);
    chk({tag, "_vld"}, char_in_vld, 0);
    chk({tag, "_load"}, load_state, 0);
    chk({tag, "_eop"}, eop, 0);
    chk({tag, "_sid"}, stream_id, 0);
    chk({tag, "_new"}, new_stream_id, 0);
    chk({tag, "_en"}, enable, 0);
    chk({tag, "_cnt"}, pkt_count, 0);
    chk({tag, "_perr"}, proto_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, in_rdy, 0);
  endtask
  initial begin
    for (int k = 0; k < 64; k++) en_m[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    cfg_write(5, 8'h03);
    send(5, 8'h61, 3, 0, -1);
    wait_idle();
    send(5, 8'h61, 3, 0, -1);
    wait_idle();
    cfg_write(7, 8'hA5);
    send(7, 8'h01, 4, 1, -1);
    send(7, 8'h05, 3, 1, -1);
    wait_idle();
    drive_byte(8'hAA, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("orphan_perr_count", n_perr, 1);
    chk("orphan_no_busy", busy, 0);
    @(posedge clk); #1;
    cfg_flush = 1;
    @(posedge clk); #1;
    cfg_flush = 0;
    seen_m = 0;
    send(5, 8'h30, 2, 0, -1);
    wait_idle();
    cfg_write(9, 8'h5A);
    send(9, 8'h40, 4, 0, 2);
    wait_idle();
    send(9, 8'h50, 2, 0, -1);
    wait_idle();
    push_hdr(5);
    drive_byte(8'h10, 5, 1, 0, 0, 1);
    drive_byte(8'h11, 5, 0, 0, 0, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    chk("midrst_hdr_q", q_hdr.size(), 0);
    chk("midrst_chr_q", q_chr.size(), 0);
    @(posedge clk); #1;
    rst = 0;
    seen_m = 0; pkt_m = 0;
    for (int k = 0; k < 64; k++) en_m[k] = 0;
    send(5, 8'h20, 3, 0, -1);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("end_hdr_q", q_hdr.size(), 0);
    chk("end_chr_q", q_chr.size(), 0);
    chk("end_perr_count", n_perr, 1);
    chk("end_pkt_count", pkt_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
